// File: rtl/axis_frame_checker_pkg.sv
// Shared definitions for the AXI-Stream frame checker slice.
package axis_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECV   = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   localparam int unsigned FRAME_CNT_W = 16;
   localparam int unsigned STRB_MAX    = 128;

   // All-ones strobe mask of n byte lanes, right-aligned in a wide vector.
   function automatic logic [STRB_MAX-1:0] strb_ones(input int unsigned n);
      logic [STRB_MAX-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < STRB_MAX; k++) begin
         if (k < n) m[k] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_frame_checker_throttle.sv
// tready throttle: drops allow for one cycle in every READY_PERIOD enabled cycles.
module axis_ready_throttle #(
   parameter int unsigned READY_PERIOD = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic allow
);

   localparam int unsigned THR_W = (READY_PERIOD > 2) ? $clog2(READY_PERIOD) : 1;
   localparam int unsigned LAST  = (READY_PERIOD > 0) ? READY_PERIOD - 1 : 0;

   logic [THR_W-1:0] r_thr;

   // Wrapping counter 0..READY_PERIOD-1, frozen while disabled; stays 0 when unthrottled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_thr <= '0;
      end else if (enable) begin
         r_thr <= (r_thr == THR_W'(LAST)) ? '0 : r_thr + 1'b1;
      end
   end

   assign allow = (READY_PERIOD == 0) || (r_thr != THR_W'(LAST));

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream sink that checks tlast-delimited frames and reports length/sum/count.
module axis_frame_checker
   import axis_chk_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned LEN_WIDTH     = 16,
   parameter int unsigned MAX_FRAME_LEN = 4096,
   parameter int unsigned READY_PERIOD  = 0,
   parameter int unsigned CHECK_SEQ     = 1
) (
   input  logic                      s04_axis_aclk,
   input  logic                      s04_axis_areset,
   input  logic                      s04_axis_enable,
   input  logic [DATA_WIDTH-1:0]     s04_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s04_axis_tstrb,
   input  logic                      s04_axis_tvalid,
   input  logic                      s04_axis_tlast,
   output logic                      s04_axis_tready,
   input  logic                      err_clear,
   output logic                      frame_done,
   output logic [LEN_WIDTH-1:0]      frame_len,
   output logic [DATA_WIDTH-1:0]     frame_sum,
   output logic [FRAME_CNT_W-1:0]    frame_count,
   output logic                      seq_err,
   output logic                      strb_err,
   output logic                      len_err
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   state_t                r_state;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [DATA_WIDTH-1:0] r_sum;
   logic [DATA_WIDTH-1:0] r_expect;

   logic                  w_allow;
   logic                  w_accept;
   logic                  w_first;
   logic [LEN_WIDTH-1:0]  w_len_next;
   logic [DATA_WIDTH-1:0] w_sum_next;
   logic                  w_seq_bad;
   logic                  w_strb_bad;
   logic                  w_force;
   logic                  w_term;

   axis_ready_throttle #(
      .READY_PERIOD (READY_PERIOD)
   ) u_throttle (
      .clk    (s04_axis_aclk),
      .reset  (s04_axis_areset),
      .enable (s04_axis_enable),
      .allow  (w_allow)
   );

   assign s04_axis_tready = s04_axis_enable && (r_state != ST_REPORT) && w_allow;
   assign w_accept        = s04_axis_tvalid && s04_axis_tready;

   // Next accumulator values and per-beat checks for the beat currently offered.
   // A forced termination at MAX_FRAME_LEN is evaluated in IDLE too, so a
   // MAX_FRAME_LEN of 1 turns every untagged beat into its own overlong frame.
   always_comb begin
      w_first    = (r_state == ST_IDLE);
      w_len_next = w_first ? LEN_WIDTH'(1) : r_len + 1'b1;
      w_sum_next = w_first ? s04_axis_tdata : r_sum + s04_axis_tdata;
      w_seq_bad  = (CHECK_SEQ != 0) && !w_first && (s04_axis_tdata != r_expect);
      w_strb_bad = (s04_axis_tstrb != STRB_W'(strb_ones(STRB_W)));
      w_force    = !s04_axis_tlast && (w_len_next == LEN_WIDTH'(MAX_FRAME_LEN));
      w_term     = s04_axis_tlast || w_force;
   end

   // Frame FSM: accumulate beats, then spend one REPORT cycle publishing results.
   always_ff @(posedge s04_axis_aclk) begin
      if (s04_axis_areset) begin
         r_state     <= ST_IDLE;
         r_len       <= '0;
         r_sum       <= '0;
         r_expect    <= '0;
         frame_done  <= 1'b0;
         frame_len   <= '0;
         frame_sum   <= '0;
         frame_count <= '0;
      end else begin
         frame_done <= 1'b0;
         unique case (r_state)
            ST_IDLE, ST_RECV: begin
               if (w_accept) begin
                  r_len    <= w_len_next;
                  r_sum    <= w_sum_next;
                  r_expect <= s04_axis_tdata + 1'b1;
                  if (w_term) begin
                     r_state     <= ST_REPORT;
                     frame_done  <= 1'b1;
                     frame_len   <= w_len_next;
                     frame_sum   <= w_sum_next;
                     frame_count <= frame_count + 1'b1;
                  end else begin
                     r_state <= ST_RECV;
                  end
               end
            end
            ST_REPORT: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error flags; a new error event beats a simultaneous clear.
   always_ff @(posedge s04_axis_aclk) begin
      if (s04_axis_areset) begin
         seq_err  <= 1'b0;
         strb_err <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         seq_err  <= (w_accept && w_seq_bad)  || (seq_err  && !err_clear);
         strb_err <= (w_accept && w_strb_bad) || (strb_err && !err_clear);
         len_err  <= (w_accept && w_force)    || (len_err  && !err_clear);
      end
   end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: two instances (unthrottled/MAX 8, throttled/MAX 4096)
// checked every cycle against a frame-level model, plus literal checkpoints.
module tb_axis_frame_checker;

   logic        clk;
   logic        rst;
   logic        en     [2];
   logic [31:0] tdata  [2];
   logic [3:0]  tstrb  [2];
   logic        tvalid [2];
   logic        tlast  [2];
   logic        tready [2];
   logic        clr    [2];
   logic        done   [2];
   logic [15:0] flen   [2];
   logic [31:0] fsum   [2];
   logic [15:0] fcnt   [2];
   logic        seq    [2];
   logic        strb   [2];
   logic        lerr   [2];

   int total = 0;
   int bad   = 0;
   bit started = 0;

   axis_frame_checker #(
      .DATA_WIDTH(32), .LEN_WIDTH(16), .MAX_FRAME_LEN(8), .READY_PERIOD(0), .CHECK_SEQ(1)
   ) dut0 (
      .s04_axis_aclk(clk), .s04_axis_areset(rst), .s04_axis_enable(en[0]),
      .s04_axis_tdata(tdata[0]), .s04_axis_tstrb(tstrb[0]), .s04_axis_tvalid(tvalid[0]),
      .s04_axis_tlast(tlast[0]), .s04_axis_tready(tready[0]), .err_clear(clr[0]),
      .frame_done(done[0]), .frame_len(flen[0]), .frame_sum(fsum[0]), .frame_count(fcnt[0]),
      .seq_err(seq[0]), .strb_err(strb[0]), .len_err(lerr[0])
   );

   axis_frame_checker #(
      .DATA_WIDTH(32), .LEN_WIDTH(16), .MAX_FRAME_LEN(4096), .READY_PERIOD(4), .CHECK_SEQ(1)
   ) dut1 (
      .s04_axis_aclk(clk), .s04_axis_areset(rst), .s04_axis_enable(en[1]),
      .s04_axis_tdata(tdata[1]), .s04_axis_tstrb(tstrb[1]), .s04_axis_tvalid(tvalid[1]),
      .s04_axis_tlast(tlast[1]), .s04_axis_tready(tready[1]), .err_clear(clr[1]),
      .frame_done(done[1]), .frame_len(flen[1]), .frame_sum(fsum[1]), .frame_count(fcnt[1]),
      .seq_err(seq[1]), .strb_err(strb[1]), .len_err(lerr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   bit          m_rep   [2];
   int unsigned m_thr   [2];
   int unsigned m_cnt   [2];
   logic [31:0] m_beats [2][16];
   logic        e_done  [2];
   logic [15:0] e_len   [2];
   logic [31:0] e_sum   [2];
   logic [15:0] e_cnt   [2];
   logic        e_seq   [2];
   logic        e_strb  [2];
   logic        e_lerr  [2];

   function automatic int unsigned per(input int i);
      return (i == 0) ? 0 : 4;
   endfunction

   function automatic int unsigned mx(input int i);
      return (i == 0) ? 8 : 4096;
   endfunction

   function automatic bit exp_rdy(input int i);
      return en[i] && !m_rep[i] && !(per(i) != 0 && m_thr[i] == per(i) - 1);
   endfunction

   task automatic model_step(input int i);
      bit acc, sseq, sstrb, slen, dn;
      logic [31:0] s;
      if (rst) begin
         m_rep[i] = 0; m_thr[i] = 0; m_cnt[i] = 0;
         e_done[i] = 0; e_len[i] = '0; e_sum[i] = '0; e_cnt[i] = '0;
         e_seq[i] = 0; e_strb[i] = 0; e_lerr[i] = 0;
      end else begin
         acc = tvalid[i] && exp_rdy(i);
         sseq = 0; sstrb = 0; slen = 0; dn = 0;
         m_rep[i] = 0;
         if (acc) begin
            if (tstrb[i] != 4'hF) sstrb = 1;
            if (m_cnt[i] > 0 && tdata[i] != m_beats[i][(m_cnt[i] - 1) % 16] + 32'd1) sseq = 1;
            m_beats[i][m_cnt[i] % 16] = tdata[i];
            m_cnt[i]++;
            if (tlast[i] || m_cnt[i] == mx(i)) begin
               s = '0;
               for (int k = 0; k < int'(m_cnt[i]); k++) s = s + m_beats[i][k % 16];
               dn = 1;
               e_len[i] = 16'(m_cnt[i]);
               e_sum[i] = s;
               e_cnt[i] = e_cnt[i] + 16'd1;
               slen = !tlast[i];
               m_rep[i] = 1;
               m_cnt[i] = 0;
            end
         end
         e_done[i] = dn;
         e_seq[i]  = sseq  || (e_seq[i]  && !clr[i]);
         e_strb[i] = sstrb || (e_strb[i] && !clr[i]);
         e_lerr[i] = slen  || (e_lerr[i] && !clr[i]);
         if (en[i]) m_thr[i] = (per(i) == 0) ? 0 : (m_thr[i] + 1) % per(i);
      end
   endtask

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_tready", i), 64'(tready[i]), 64'(exp_rdy(i)));
            chk($sformatf("d%0d_done", i),   64'(done[i]),   64'(e_done[i]));
            chk($sformatf("d%0d_len", i),    64'(flen[i]),   64'(e_len[i]));
            chk($sformatf("d%0d_sum", i),    64'(fsum[i]),   64'(e_sum[i]));
            chk($sformatf("d%0d_count", i),  64'(fcnt[i]),   64'(e_cnt[i]));
            chk($sformatf("d%0d_seq", i),    64'(seq[i]),    64'(e_seq[i]));
            chk($sformatf("d%0d_strb", i),   64'(strb[i]),   64'(e_strb[i]));
            chk($sformatf("d%0d_lenerr", i), 64'(lerr[i]),   64'(e_lerr[i]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input int i, input logic [31:0] d, input logic [3:0] s,
                       input logic l, input logic c);
      bit a;
      int n;
      tvalid[i] = 1; tdata[i] = d; tstrb[i] = s; tlast[i] = l; clr[i] = c;
      a = 0; n = 0;
      while (!a && n < 20) begin
         @(negedge clk);
         a = exp_rdy(i);
         @(posedge clk);
         #1;
         n++;
      end
      if (!a) begin
         total++; bad++;
         $display("FAIL send_timeout: beat %0h on d%0d not accepted within 20 cycles", d, i);
      end
      tvalid[i] = 0; tlast[i] = 0; clr[i] = 0;
   endtask

   task automatic pulse_clr(input int i);
      clr[i] = 1;
      @(posedge clk); #1;
      clr[i] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         en[i] = 1; tdata[i] = '0; tstrb[i] = '0; tvalid[i] = 0; tlast[i] = 0; clr[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 0;
      started = 1;

      // reset state
      chk("rst_done", 64'(done[0]), 0);
      chk("rst_count", 64'(fcnt[0]), 0);
      chk("rst_len", 64'(flen[0]), 0);
      chk("rst_errs", 64'({seq[0], strb[0], lerr[0]}), 0);

      // 1: clean 4-beat frame
      for (int k = 0; k < 4; k++) send(0, 32'h10 + 32'(k), 4'hF, k == 3, 0);
      chk("t1_done", 64'(done[0]), 1);
      chk("t1_len", 64'(flen[0]), 4);
      chk("t1_sum", 64'(fsum[0]), 64'h46);
      chk("t1_count", 64'(fcnt[0]), 1);
      chk("t1_tready_report", 64'(tready[0]), 0);
      chk("t1_errs", 64'({seq[0], strb[0], lerr[0]}), 0);
      @(posedge clk); #1;
      chk("t1_tready_after", 64'(tready[0]), 1);
      chk("t1_done_after", 64'(done[0]), 0);

      // 2: sequence break 5,6,8,9
      send(0, 32'd5, 4'hF, 0, 0);
      send(0, 32'd6, 4'hF, 0, 0);
      chk("t2_seq_before", 64'(seq[0]), 0);
      send(0, 32'd8, 4'hF, 0, 0);
      chk("t2_seq_after8", 64'(seq[0]), 1);
      send(0, 32'd9, 4'hF, 1, 0);
      chk("t2_len", 64'(flen[0]), 4);
      chk("t2_sum", 64'(fsum[0]), 64'h1C);
      pulse_clr(0);
      chk("t2_seq_cleared", 64'(seq[0]), 0);

      // 3: strobe error, clear, then clear colliding with a bad beat
      send(0, 32'h20, 4'hF, 0, 0);
      send(0, 32'h21, 4'hE, 0, 0);
      chk("t3_strb_set", 64'(strb[0]), 1);
      send(0, 32'h22, 4'hF, 1, 0);
      pulse_clr(0);
      chk("t3_strb_cleared", 64'(strb[0]), 0);
      send(0, 32'h30, 4'hF, 0, 0);
      send(0, 32'h31, 4'hE, 0, 1);
      chk("t3_strb_setwins", 64'(strb[0]), 1);
      send(0, 32'h32, 4'hF, 1, 0);
      chk("t3_count", 64'(fcnt[0]), 4);
      pulse_clr(0);

      // 4: forced termination at MAX_FRAME_LEN=8
      for (int k = 0; k < 8; k++) send(0, 32'(k), 4'hF, 0, 0);
      chk("t4_done", 64'(done[0]), 1);
      chk("t4_lenerr", 64'(lerr[0]), 1);
      chk("t4_len", 64'(flen[0]), 8);
      chk("t4_sum", 64'(fsum[0]), 64'h1C);
      chk("t4_count", 64'(fcnt[0]), 5);
      send(0, 32'd8, 4'hF, 0, 0);
      send(0, 32'd9, 4'hF, 1, 0);
      chk("t4_next_len", 64'(flen[0]), 2);
      chk("t4_next_sum", 64'(fsum[0]), 64'h11);
      chk("t4_next_seq", 64'(seq[0]), 0);
      pulse_clr(0);

      // enable low holds tready low and stalls a pending beat
      en[0] = 0; tvalid[0] = 1; tdata[0] = 32'h40; tstrb[0] = 4'hF; tlast[0] = 1;
      repeat (3) begin
         @(negedge clk);
         chk("en_low_tready", 64'(tready[0]), 0);
      end
      @(posedge clk); #1;
      en[0] = 1;
      send(0, 32'h40, 4'hF, 1, 0);
      chk("en_count", 64'(fcnt[0]), 7);
      chk("en_sum", 64'(fsum[0]), 64'h40);

      // 5: throttled sink, tvalid held high across the frame
      for (int k = 1; k <= 8; k++) send(1, 32'(k), 4'hF, k == 8, 0);
      chk("t5_len", 64'(flen[1]), 8);
      chk("t5_sum", 64'(fsum[1]), 64'h24);
      chk("t5_count", 64'(fcnt[1]), 1);
      chk("t5_seq", 64'(seq[1]), 0);
      // data wrapping through all-ones is a legal sequence
      send(1, 32'hFFFF_FFFE, 4'hF, 0, 0);
      send(1, 32'hFFFF_FFFF, 4'hF, 0, 0);
      send(1, 32'h0000_0000, 4'hF, 0, 0);
      send(1, 32'h0000_0001, 4'hF, 1, 0);
      chk("wrap_sum", 64'(fsum[1]), 64'hFFFF_FFFE);
      chk("wrap_seq", 64'(seq[1]), 0);

      // 6: reset mid-frame
      send(0, 32'h50, 4'hF, 0, 0);
      send(0, 32'h51, 4'hF, 0, 0);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("t6_count_rst", 64'(fcnt[0]), 0);
      chk("t6_done_rst", 64'(done[0]), 0);
      send(0, 32'hFFFF_FFFF, 4'hF, 1, 0);
      chk("t6_done", 64'(done[0]), 1);
      chk("t6_count", 64'(fcnt[0]), 1);
      chk("t6_len", 64'(flen[0]), 1);
      chk("t6_sum", 64'(fsum[0]), 64'hFFFF_FFFF);
      chk("t6_errs", 64'({seq[0], strb[0], lerr[0]}), 0);

      repeat (4) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
